// File: rtl/shift_deserializer_pkg.sv
// Shared types and constants for shift_deserializer.
// Optional build macro: SHIFT_DESERIALIZER_PARITY_EN (adds the PARITY state).
package shift_deserializer_pkg;

  localparam int   SD_DEFAULT_WIDTH = 4;
  localparam logic DIR_LSB_FIRST    = 1'b0;
  localparam logic DIR_MSB_FIRST    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_HOLD   = 2'd2
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    ,
    ST_PARITY = 2'd3
`endif
  } sd_state_e;

endpackage

// File: rtl/shift_deserializer_bit_counter.sv
// Bit counter for shift_deserializer: clear / load-to-one / increment,
// with a terminal-count flag raised while the next bit completes a word.
module bit_counter #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CW-1:0] count_q;

  // Count captured bits; clear has priority, then load, then increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(1);
    end else if (inc_i && (count_q != CW'(MAX))) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tc_o = (count_q == CW'(MAX - 1));

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with LSB/MSB-first order, ready/valid
// output handshake and sticky overrun flag.
// Optional build macro: SHIFT_DESERIALIZER_PARITY_EN (even parity bit after
// each word, reported on parity_err_o).
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH = SD_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             ser_in_i,
  input  logic             ser_valid_i,
  input  logic             dir_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             overrun_o
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  ,
  output logic             parity_err_o
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  sd_state_e        state_q;
  logic [WIDTH-1:0] buf_q;
  logic             dir_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             overrun_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic             par_q;
  logic             parity_err_q;
`endif

  logic capture_first;
  logic cnt_inc;
  logic cnt_clr;
  logic cnt_tc;

  function automatic logic [WIDTH-1:0] shift_bit(input logic [WIDTH-1:0] b,
                                                 input logic d,
                                                 input logic dir);
    logic [WIDTH-1:0] r;
    r = b;
    case (dir)
      DIR_LSB_FIRST: r = {d, b[WIDTH-1:1]};
      DIR_MSB_FIRST: r = {b[WIDTH-2:0], d};
      default:       r = b;
    endcase
    return r;
  endfunction

  // Decide how the bit counter moves this cycle.
  always_comb begin
    capture_first = 1'b0;
    cnt_inc       = 1'b0;
    cnt_clr       = clr_i;
    case (state_q)
      ST_IDLE:  capture_first = ser_valid_i;
      ST_SHIFT: begin
        if (ser_valid_i) begin
          if (cnt_tc) cnt_clr = 1'b1;
          else        cnt_inc = 1'b1;
        end
      end
      ST_HOLD:  capture_first = ser_valid_i & out_ready_i;
      default:  ;
    endcase
  end

  bit_counter #(
    .MAX (WIDTH),
    .CW  (CNT_W)
  ) u_bit_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .load_i (capture_first),
    .inc_i  (cnt_inc),
    .tc_o   (cnt_tc)
  );

  // Main FSM: captures bits, assembles the word and drives registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      dir_q        <= DIR_LSB_FIRST;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else if (clr_i) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      dir_q        <= DIR_LSB_FIRST;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ser_valid_i) begin
            // First bit of a word always shifts into a cleared buffer.
            buf_q   <= shift_bit('0, ser_in_i, dir_i);
            dir_q   <= dir_i;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            par_q   <= ser_in_i;
`endif
          end
        end
        ST_SHIFT: begin
          if (ser_valid_i) begin
            buf_q <= shift_bit(buf_q, ser_in_i, dir_q);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            par_q <= par_q ^ ser_in_i;
            if (cnt_tc) state_q <= ST_PARITY;
`else
            if (cnt_tc) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
`endif
          end
        end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (ser_valid_i) begin
            parity_err_q <= par_q ^ ser_in_i;
            state_q      <= ST_HOLD;
            out_valid_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
`endif
        ST_HOLD: begin
          if (out_ready_i) begin
            out_valid_q  <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (ser_valid_i) begin
              // Word consumed and next word starts on the same edge.
              buf_q   <= shift_bit('0, ser_in_i, dir_i);
              dir_q   <= dir_i;
              busy_q  <= 1'b1;
              state_q <= ST_SHIFT;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
              par_q   <= ser_in_i;
`endif
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (ser_valid_i) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data_o  = buf_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (legal range 2..8).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 CLR  input  1  synchronous abort: clears state, data and flags.
REQ-005 SER_IN  input  1  serial bit, i.e. the bit shifted out of the shift register (its FLAG output).
REQ-006 SER_VALID  input  1  SER_IN holds a valid bit this cycle.
REQ-007 DIR  input  1  bit order, sampled with the first bit of a word: 0 = LSB-first (RSH source), 1 = MSB-first (LSH source).
REQ-008 OUT_DATA  output  WIDTH  assembled word, stable while OUT_VALID=1.
REQ-009 OUT_VALID  output  1  word available.
REQ-010 OUT_READY  input  1  consumer accepts the word; transfer occurs when OUT_VALID=1 and OUT_READY=1.
REQ-011 BUSY  output  1  word partially received (state SHIFT or PARITY).
REQ-012 OVERRUN  output  1  sticky: a bit arrived while a word was held and not accepted.
REQ-013 PARITY_ERR  output  1  present only with SHIFT_DESERIALIZER_PARITY_EN; see REQ-030.

Function
REQ-014 States: IDLE, SHIFT, PARITY (macro only), HOLD; one-hot or binary encoding permitted.
REQ-015 A bit is captured only on a rising edge where SER_VALID=1; SER_VALID=0 stalls with no state, count or data change.
REQ-016 IDLE + SER_VALID: capture bit, latch DIR, count=1, go SHIFT.
REQ-017 DIR latched=0: shift buffer <= {bit, buf[WIDTH-1:1]}; DIR latched=1: buffer <= {buf[WIDTH-2:0], bit}.
REQ-018 DIR changes after the first bit of a word are ignored until the next word.
REQ-019 SHIFT: on the WIDTH-th captured bit go HOLD (or PARITY with macro); count resets to 0.
REQ-020 OUT_VALID asserts on the edge that captures the last bit (data or parity); latency = 0 cycles after that edge, OUT_DATA valid in the same cycle.
REQ-021 HOLD: OUT_DATA and OUT_VALID held until transfer; on transfer with SER_VALID=0 go IDLE, OUT_VALID=0.
REQ-022 HOLD, transfer and SER_VALID=1 in same cycle: word consumed, incoming bit captured as first bit of next word, go SHIFT.
REQ-023 HOLD, SER_VALID=1, OUT_READY=0: bit dropped, OVERRUN set, held word unchanged.
REQ-024 OUT_READY while OUT_VALID=0 has no effect.
REQ-025 CLR=1: state IDLE, count 0, buffer 0, OUT_VALID=0, OVERRUN=0, PARITY_ERR=0; CLR overrides all other inputs in that cycle.
REQ-026 Bit counter width = clog2(WIDTH+1); never exceeds WIDTH.

Reset
REQ-027 RESET=1 forces immediately, independent of CLK: state IDLE, count 0, OUT_DATA=0, OUT_VALID=0, BUSY=0, OVERRUN=0, PARITY_ERR=0.
REQ-028 RESET mid-word discards partial data; the first valid bit after release starts a new word.

Configuration
REQ-029 Macro SHIFT_DESERIALIZER_PARITY_EN enables parity support; without it the PARITY state, the PARITY_ERR port and all parity logic are absent and SHIFT goes directly to HOLD.
REQ-030 With the macro, one even-parity bit follows the WIDTH data bits; it is captured in PARITY (stalls per REQ-015) and is not stored in OUT_DATA; PARITY_ERR = XOR(data bits, parity bit), valid with OUT_VALID and cleared on transfer.

Structure
REQ-031 Shared package holds the state encoding, the DIR_LSB_FIRST/DIR_MSB_FIRST constants and the default WIDTH constant.
REQ-032 One sub-module, bit_counter (load/increment/clear, terminal-count output), is instantiated; all other logic is in shift_deserializer.

Verification
REQ-033 DIR=0, bits 0,1,0,0 on consecutive edges, OUT_READY=0 -> OUT_VALID=1, OUT_DATA=4'b0010 after the 4th edge, held until OUT_READY=1.
REQ-034 DIR=1, bits 1,0,1,1 with SER_VALID=0 on two cycles inserted -> OUT_DATA=4'b1011, BUSY=1 throughout the stalls.
REQ-035 Word held, OUT_READY=0, SER_VALID=1 -> OVERRUN=1, OUT_DATA unchanged; then CLR=1 -> OVERRUN=0, OUT_VALID=0.
REQ-036 Word held, OUT_READY=1 and SER_VALID=1 (bit 1) same edge, then DIR=0 bits 1,1,1 -> first word consumed, second OUT_DATA=4'b1111.
REQ-037 RESET pulsed mid-CLK after 2 bits -> outputs 0 at once; next 4 bits 1,0,0,0 (DIR=0) -> OUT_DATA=4'b0001.
REQ-038 With macro: data 1,1,0,0 (DIR=0) parity 1 -> OUT_DATA=4'b0011, PARITY_ERR=1; parity 0 -> PARITY_ERR=0.
